// File: rtl/ts_pkg.sv
// Shared constants, header field layouts and FSM state type for the
// MPEG-2 TS packet generator.
package ts_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PID_W  = 13;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned CNT_W  = 32;

  localparam logic [BYTE_W-1:0] TS_SYNC_BYTE     = 8'h47;
  localparam int unsigned       TS_PKT_LEN       = 188;
  localparam int unsigned       TS_HDR_LEN       = 4;
  localparam logic [1:0]        AFC_PAYLOAD_ONLY = 2'b01;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} ts_state_e;

  // Header byte 1: error/start/priority flags plus the PID high bits
  typedef struct packed {
    logic       tei;
    logic       pusi;
    logic       prio;
    logic [4:0] pid_hi;
  } ts_hdr_b1_t;

  // Header byte 3: scrambling control, adaptation field control, CC
  typedef struct packed {
    logic [1:0]      scr;
    logic [1:0]      afc;
    logic [CC_W-1:0] cc;
  } ts_hdr_b3_t;

endpackage

// File: rtl/ts_header_builder.sv
// Combinational TS header byte selector.
// Ports:
//   idx_i      - header byte index 0..3
//   pid_i      - PID of the packet being built
//   cc_i       - continuity counter of the packet being built
//   hdr_byte_c - header byte for idx_i (combinational)
module ts_header_builder
  import ts_pkg::*;
(
  input  logic [1:0]        idx_i,
  input  logic [PID_W-1:0]  pid_i,
  input  logic [CC_W-1:0]   cc_i,
  output logic [BYTE_W-1:0] hdr_byte_c
);

  ts_hdr_b1_t b1_c;
  ts_hdr_b3_t b3_c;

  assign b1_c = '{tei: 1'b0, pusi: 1'b1, prio: 1'b0, pid_hi: pid_i[12:8]};
  assign b3_c = '{scr: 2'b00, afc: AFC_PAYLOAD_ONLY, cc: cc_i};

  always_comb begin
    hdr_byte_c = TS_SYNC_BYTE;
    case (idx_i)
      2'd1:    hdr_byte_c = b1_c;
      2'd2:    hdr_byte_c = pid_i[7:0];
      2'd3:    hdr_byte_c = b3_c;
      default: hdr_byte_c = TS_SYNC_BYTE;
    endcase
  end

endmodule

// File: rtl/ts_packet_generator.sv
// MPEG-2 TS packet source feeding one FIFO write port with a valid/ready
// byte stream: sync byte, PID, continuity counter and a counting payload.
// Optional macro LOSS_INJECT_EN: every DROP_PERIOD completed packets the CC
// skips one value to emulate a lost packet.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   enable     - start/continue generation (packets never truncated)
//   pid        - PID, latched at packet start
//   gap        - idle cycles between packets, sampled on the eop transfer
//   ready      - sink can accept a byte
//   byte_data  - stream byte, valid with valid
//   sop, eop   - first / last byte of a packet
//   cc_out     - CC of the packet in flight
//   pkt_count  - packets fully transferred
module ts_packet_generator
  import ts_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PKT_LEN     = TS_PKT_LEN,
  parameter int unsigned DROP_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PID_W-1:0]      pid,
  input  logic [GAP_W-1:0]      gap,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic                  valid,
  output logic                  sop,
  output logic                  eop,
  output logic [CC_W-1:0]       cc_out,
  output logic [CNT_W-1:0]      pkt_count
);

  localparam int unsigned      IDX_W     = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] FIRST_PLD = IDX_W'(TS_HDR_LEN);

  ts_state_e                 state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [PID_W-1:0]          pid_q;
  logic [CC_W-1:0]           cc_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [GAP_W-1:0]          gap_q;
  logic                      valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0]     data_q;

  logic                      xfer_c, last_xfer_c, start_c;
  logic [IDX_W-1:0]          nidx_c;
  logic [BYTE_W-1:0]         hdr_c, payload_c, next_byte_c;
  logic [CC_W-1:0]           cc_next_c;

  assign xfer_c      = valid_q & ready;
  assign last_xfer_c = xfer_c & eop_q;
  assign nidx_c      = idx_q + IDX_W'(1);

  // Next byte is prepared while the current one is on the bus
  ts_header_builder u_hdr (
    .idx_i      (nidx_c[1:0]),
    .pid_i      (pid_q),
    .cc_i       (cc_q),
    .hdr_byte_c (hdr_c)
  );

  assign payload_c   = BYTE_W'(cnt_q[BYTE_W-1:0] + BYTE_W'(nidx_c) - BYTE_W'(TS_HDR_LEN));
  assign next_byte_c = (nidx_c < FIRST_PLD) ? hdr_c : payload_c;

  // A new packet header is launched from idle, after the gap, or back-to-back
  always_comb begin
    start_c = 1'b0;
    case (state_q)
      IDLE:            start_c = enable;
      HEADER, PAYLOAD: start_c = last_xfer_c & enable & (gap == '0);
      GAP:             start_c = enable & (gap_q <= GAP_W'(1));
      default:         start_c = 1'b0;
    endcase
  end

`ifdef LOSS_INJECT_EN
  localparam int unsigned DROP_W = $clog2(DROP_PERIOD + 1);
  logic [DROP_W-1:0] drop_q;
  logic              drop_hit_c;

  assign drop_hit_c = (drop_q + DROP_W'(1)) == DROP_W'(DROP_PERIOD);
  assign cc_next_c  = drop_hit_c ? cc_q + CC_W'(2) : cc_q + CC_W'(1);

  // Completed-packet counter that schedules the emulated loss
  always_ff @(posedge clk) begin
    if (rst)              drop_q <= '0;
    else if (last_xfer_c) drop_q <= drop_hit_c ? '0 : drop_q + DROP_W'(1);
  end
`else
  logic [31:0] unused_drop_period_c;
  assign unused_drop_period_c = 32'(DROP_PERIOD);
  assign cc_next_c            = cc_q + CC_W'(1);
`endif

  // Packet FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pid_q   <= '0;
      cc_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      if (last_xfer_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
        cc_q  <= cc_next_c;
        gap_q <= gap;
      end
      if (start_c) begin
        state_q <= HEADER;
        idx_q   <= '0;
        pid_q   <= pid;
        valid_q <= 1'b1;
        sop_q   <= 1'b1;
        eop_q   <= 1'b0;
        data_q  <= DATA_WIDTH'(TS_SYNC_BYTE);
      end else begin
        case (state_q)
          HEADER, PAYLOAD: begin
            if (xfer_c) begin
              if (eop_q) begin
                state_q <= GAP;
                idx_q   <= '0;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
              end else begin
                idx_q  <= nidx_c;
                data_q <= DATA_WIDTH'(next_byte_c);
                sop_q  <= 1'b0;
                eop_q  <= (nidx_c == LAST_IDX);
                if (nidx_c == FIRST_PLD) state_q <= PAYLOAD;
              end
            end
          end
          GAP: begin
            if (gap_q <= GAP_W'(1)) state_q <= IDLE;
            else                    gap_q   <= gap_q - GAP_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_data = data_q;
  assign valid     = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign cc_out    = cc_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_ts_packet_generator.sv
// Self-checking bench for ts_packet_generator: randomized ready/pid/gap
// stimulus compared against a packet-level reference model.
module tb_ts_packet_generator;

  localparam int PKT_LEN = 188;
`ifdef LOSS_INJECT_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 16;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, ready;
  logic [12:0] pid;
  logic [7:0]  gap;
  logic [7:0]  byte_data;
  logic        valid, sop, eop;
  logic [3:0]  cc_out;
  logic [31:0] pkt_count;

  always #5 clk = ~clk;

  ts_packet_generator #(.DATA_WIDTH(8), .PKT_LEN(PKT_LEN), .DROP_PERIOD(DROP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pid(pid), .gap(gap), .ready(ready),
    .byte_data(byte_data), .valid(valid), .sop(sop), .eop(eop),
    .cc_out(cc_out), .pkt_count(pkt_count)
  );

  int          total = 0;
  int          bad   = 0;
  int          m_cnt = 0;     // packets completed since reset (model)
  logic [12:0] cur_pid;
  logic [7:0]  cap_q[$];
  int          lead_idle, stall_bad, flag_bad, cc_at_sop, timed_out;

  // CC of the n-th packet after reset; loss injection skips one value per DROP packets
  function automatic int model_cc(input int n);
`ifdef LOSS_INJECT_EN
    return (n + n / DROP) % 16;
`else
    return n % 16;
`endif
  endfunction

  function automatic logic [7:0] model_byte(input int n, input logic [12:0] p, input int idx);
    int cc;
    cc = model_cc(n);
    if (idx == 0)      return 8'h47;
    else if (idx == 1) return 8'h40 | 8'(p >> 8);
    else if (idx == 2) return p[7:0];
    else if (idx == 3) return 8'h10 | 8'(cc);
    else               return 8'((n + idx - 4) % 256);
  endfunction

  function automatic int first_diff(input int n, input logic [12:0] p);
    foreach (cap_q[i]) if (cap_q[i] !== model_byte(n, p, i)) return i;
    return -1;
  endfunction

  // Collect one packet's transfers; rmode 0=ready high, 1=toggle, 2=random
  task automatic get_pkt(input int rmode, input int stop_idx, input int en_off_idx,
                         input int pid_chg_idx, input logic [12:0] pid_new);
    bit rdy, seen, stalled;
    logic [7:0] hb; logic hs, he; logic [3:0] hc;
    int n;
    cap_q.delete();
    lead_idle = 0; stall_bad = 0; flag_bad = 0; cc_at_sop = -1; timed_out = 1;
    seen = 0; stalled = 0; hb = '0; hs = 0; he = 0; hc = '0;
    for (int t = 0; t < 4000; t++) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = t[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready = rdy;
      if (stalled && (!valid || byte_data !== hb || sop !== hs || eop !== he || cc_out !== hc))
        stall_bad++;
      if (!valid && (sop || eop)) flag_bad++;
      if (!valid && !seen) lead_idle++;
      if (valid) seen = 1;
      stalled = valid && !rdy;
      hb = byte_data; hs = sop; he = eop; hc = cc_out;
      if (valid && rdy) begin
        n = cap_q.size();
        if (sop !== (n == 0)) flag_bad++;
        if (eop !== (n == PKT_LEN - 1)) flag_bad++;
        if (n == 0) cc_at_sop = int'(cc_out);
        cap_q.push_back(byte_data);
        if (n == en_off_idx) enable = 1'b0;
        if (n == pid_chg_idx) pid = pid_new;
        if (n == stop_idx || eop || n == PKT_LEN - 1) begin
          timed_out = 0;
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; ready = 1'b0; pid = '0; gap = '0;
    repeat (3) @(negedge clk);
    total++; if (valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b required=0", valid); end
    total++; if (sop !== 1'b0)       begin bad++; $display("FAIL reset_sop got=%b required=0", sop); end
    total++; if (eop !== 1'b0)       begin bad++; $display("FAIL reset_eop got=%b required=0", eop); end
    total++; if (byte_data !== 8'h0) begin bad++; $display("FAIL reset_data got=%02h required=00", byte_data); end
    total++; if (cc_out !== 4'h0)    begin bad++; $display("FAIL reset_cc got=%0d required=0", cc_out); end
    total++; if (pkt_count !== 0)    begin bad++; $display("FAIL reset_cnt got=%0d required=0", pkt_count); end
    rst = 1'b0;
    m_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fd, vcnt;
    logic [31:0] hdr;
    cur_pid = 13'h0100; pid = cur_pid; gap = 8'd0; enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      get_pkt(0, -1, (k == 1) ? 3 : -1, -1, '0);
      total++; if (lead_idle != ((k == 0) ? 1 : 0)) begin bad++;
        $display("FAIL b2b_lead pkt=%0d got=%0d required=%0d", k, lead_idle, (k == 0) ? 1 : 0); end
      total++; if (timed_out != 0 || flag_bad != 0) begin bad++;
        $display("FAIL b2b_proto pkt=%0d timeout=%0d flag_errs=%0d required 0/0", k, timed_out, flag_bad); end
      total++; if (cc_at_sop != model_cc(m_cnt)) begin bad++;
        $display("FAIL b2b_cc pkt=%0d got=%0d required=%0d", k, cc_at_sop, model_cc(m_cnt)); end
      fd = first_diff(m_cnt, cur_pid);
      total++; if (fd != -1 || cap_q.size() != PKT_LEN) begin bad++;
        $display("FAIL b2b_bytes pkt=%0d len=%0d required=%0d first_bad_idx=%0d required=-1", k, cap_q.size(), PKT_LEN, fd); end
      if (k == 0 && cap_q.size() == PKT_LEN) begin
        hdr = {cap_q[0], cap_q[1], cap_q[2], cap_q[3]};
        total++; if (hdr !== 32'h47410010) begin bad++; $display("FAIL b2b_hdr got=%08h required=47410010", hdr); end
        total++; if (cap_q[PKT_LEN-1] !== model_byte(0, cur_pid, PKT_LEN - 1)) begin bad++;
          $display("FAIL b2b_last got=%02h required=%02h", cap_q[PKT_LEN-1], model_byte(0, cur_pid, PKT_LEN - 1)); end
      end
      m_cnt++;
    end
    vcnt = 0;
    repeat (6) begin if (valid) vcnt++; @(negedge clk); end
    total++; if (vcnt != 0) begin bad++; $display("FAIL b2b_drain valid_cycles got=%0d required=0", vcnt); end
    total++; if (pkt_count !== 32'(m_cnt)) begin bad++; $display("FAIL b2b_count got=%0d required=%0d", pkt_count, m_cnt); end
  endtask

  task automatic test_ready_toggle();
    int fd;
    cur_pid = 13'(($urandom() % 8191) + 1); pid = cur_pid; gap = 8'd0; enable = 1'b1;
    get_pkt(1, -1, 10, -1, '0);
    total++; if (timed_out != 0 || flag_bad != 0 || stall_bad != 0) begin bad++;
      $display("FAIL toggle_proto timeout=%0d flag_errs=%0d stall_errs=%0d required 0/0/0", timed_out, flag_bad, stall_bad); end
    fd = first_diff(m_cnt, cur_pid);
    total++; if (fd != -1 || cap_q.size() != PKT_LEN) begin bad++;
      $display("FAIL toggle_bytes len=%0d required=%0d first_bad_idx=%0d required=-1", cap_q.size(), PKT_LEN, fd); end
    m_cnt++;
    repeat (4) @(negedge clk);
    total++; if (pkt_count !== 32'(m_cnt)) begin bad++; $display("FAIL toggle_count got=%0d required=%0d", pkt_count, m_cnt); end
  endtask

  task automatic test_gap();
    int fd, g, vcnt;
    int exp_lead;
    g = $urandom_range(1, 9);
    cur_pid = 13'($urandom()); pid = cur_pid; gap = 8'd5; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_pkt(0, -1, (k == 2) ? 20 : -1, -1, '0);
      if (k == 0) gap = 8'(g);
      exp_lead = (k == 0) ? 1 : ((k == 1) ? 5 : g);
      total++; if (lead_idle != exp_lead) begin bad++;
        $display("FAIL gap_idle pkt=%0d got=%0d required=%0d", k, lead_idle, exp_lead); end
      total++; if (timed_out != 0 || flag_bad != 0) begin bad++;
        $display("FAIL gap_proto pkt=%0d timeout=%0d flag_errs=%0d required 0/0", k, timed_out, flag_bad); end
      fd = first_diff(m_cnt, cur_pid);
      total++; if (fd != -1 || cap_q.size() != PKT_LEN) begin bad++;
        $display("FAIL gap_bytes pkt=%0d len=%0d required=%0d first_bad_idx=%0d required=-1", k, cap_q.size(), PKT_LEN, fd); end
      m_cnt++;
    end
    vcnt = 0;
    repeat (14) begin if (valid) vcnt++; @(negedge clk); end
    total++; if (vcnt != 0) begin bad++; $display("FAIL gap_drain valid_cycles got=%0d required=0", vcnt); end
  endtask

  task automatic test_cc_wrap();
    logic [12:0] pids[18];
    int fd;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_cnt = 0;
    foreach (pids[i]) pids[i] = 13'($urandom());
    pid = pids[0]; gap = 8'd0; enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      cur_pid = pids[k];
      get_pkt(2, -1, (k == 16) ? 5 : -1, 50, pids[k+1]);
      total++; if (cc_at_sop != model_cc(m_cnt)) begin bad++;
        $display("FAIL wrap_cc pkt=%0d got=%0d required=%0d", k, cc_at_sop, model_cc(m_cnt)); end
      total++; if (timed_out != 0 || flag_bad != 0 || stall_bad != 0 || lead_idle != ((k == 0) ? 1 : 0)) begin bad++;
        $display("FAIL wrap_proto pkt=%0d timeout=%0d flag_errs=%0d stall_errs=%0d lead=%0d required 0/0/0/%0d",
                 k, timed_out, flag_bad, stall_bad, lead_idle, (k == 0) ? 1 : 0); end
      fd = first_diff(m_cnt, cur_pid);
      total++; if (fd != -1 || cap_q.size() != PKT_LEN) begin bad++;
        $display("FAIL wrap_bytes pkt=%0d len=%0d required=%0d first_bad_idx=%0d required=-1", k, cap_q.size(), PKT_LEN, fd); end
      m_cnt++;
    end
    repeat (4) @(negedge clk);
    total++; if (pkt_count !== 32'(m_cnt)) begin bad++; $display("FAIL wrap_count got=%0d required=%0d", pkt_count, m_cnt); end
  endtask

  task automatic test_reset_mid();
    int fd;
    cur_pid = 13'($urandom()); pid = cur_pid; gap = 8'd0; enable = 1'b1;
    get_pkt(0, 100, -1, -1, '0);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    m_cnt = 0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b required=0", valid); end
    total++; if (pkt_count !== 32'(m_cnt) || cc_out !== 4'(model_cc(m_cnt))) begin bad++;
      $display("FAIL rstmid_state cnt=%0d cc=%0d required %0d/%0d", pkt_count, cc_out, m_cnt, model_cc(m_cnt)); end
    rst = 1'b0; enable = 1'b1;
    get_pkt(2, -1, 10, -1, '0);
    total++; if (cc_at_sop != model_cc(m_cnt) || lead_idle != 1) begin bad++;
      $display("FAIL rstmid_cc got=%0d lead=%0d required=%0d lead=1", cc_at_sop, lead_idle, model_cc(m_cnt)); end
    fd = first_diff(m_cnt, cur_pid);
    total++; if (fd != -1 || cap_q.size() != PKT_LEN) begin bad++;
      $display("FAIL rstmid_bytes len=%0d required=%0d first_bad_idx=%0d required=-1", cap_q.size(), PKT_LEN, fd); end
    m_cnt++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_toggle();
    test_gap();
    test_cc_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
